pulpino_boot_seq: RTL and testbench

Board-level bring-up controller for the PULPino SoC on the FPGA board. It sequences the core from board clock to running code:
- generates the divided core clock with a phase tick
- holds the core reset for a programmed number of core cycles
- debounces the raw fetch-enable button and gates fetch_enable through a run/halt state machine
- drives a reset-clean heartbeat LED

It sits between the board pins and pulpino_top in the FPGA top wrapper.

---
 rtl/pulpino_boot_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_pulpino_boot_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pulpino_boot_seq.sv
// Purpose: PULPino board bring-up: core clock divider with phase tick, timed core reset, debounced fetch-enable run/halt FSM, heartbeat LED.
// Latency: FSM outputs are registered and change only on the tick edge (core_clk_o falling); the button takes 2 sync + DEBOUNCE_CYCLES clk.
// Backpressure: none; all inputs are levels or single-cycle pulses with no handshake.
// Optional: define PULPINO_BOOT_SEQ_WDOG_EN to build in the RUN-state watchdog (WDOG_TICKS, wdog_kick_i, wdog_trip_o).
module pulpino_boot_seq #(
  parameter int CLK_DIV         = 11,
  parameter int RST_HOLD_CYCLES = 1024,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HB_PERIOD       = 50000000,
  parameter int WDOG_TICKS      = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_rst_i,
  input  logic       fetch_req_n_i,
  input  logic       halt_i,
  input  logic       wdog_kick_i,
  output logic       core_clk_o,
  output logic       tick_o,
  output logic       core_rst_n_o,
  output logic       fetch_enable_o,
  output logic [1:0] state_o,
  output logic       heartbeat_o,
  output logic       wdog_trip_o
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  // Counters are sized to their terminal value; a limit of 1 still needs one bit.
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HB_W   = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_PERIOD - 1);
  localparam logic [HB_W-1:0]   HB_HALF   = HB_W'(HB_PERIOD / 2);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              core_clk_q, core_clk_d;
  logic              tick;
  logic              sync1_q, sync2_q;
  logic              deb_req_q, deb_req_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              req_sync;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              fetch_en_q, fetch_en_d;
  logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic              hb_q, hb_d;
  logic              wdog_fire;

  // Divider: core clock toggles each time the phase counter wraps.
  always_comb begin
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    core_clk_d = core_clk_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d  = '0;
      core_clk_d = ~core_clk_q;
    end
  end

  // Divider state; keeps running through soft reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      core_clk_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      core_clk_q <= core_clk_d;
    end
  end

  // Tick marks the clk cycle whose closing edge is the core clock falling edge.
  assign tick = (div_cnt_q == DIV_LAST) && core_clk_q;

  // Debounce: the request only flips after the synced button differs for DEBOUNCE_CYCLES cycles in a row.
  assign req_sync = ~sync2_q;
  always_comb begin
    deb_cnt_d = '0;
    deb_req_d = deb_req_q;
    if (req_sync != deb_req_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_req_d = req_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Synchronizer and debounce state, every clk cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_req_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= fetch_req_n_i;
      sync2_q   <= sync1_q;
      deb_req_q <= deb_req_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

`ifdef PULPINO_BOOT_SEQ_WDOG_EN
  localparam int WD_W = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_TICKS - 1);

  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_trip_q;

  // Trip fires on a RUN tick that reaches the limit unless a kick or soft reset lands in the same cycle.
  assign wdog_fire = tick && (state_q == ST_RUN) && !wdog_kick_i && !soft_rst_i && (wdog_cnt_q == WD_LAST);

  // Watchdog counts RUN ticks since the last kick; cleared outside RUN and whenever the FSM leaves via a tick.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if ((state_q != ST_RUN) || wdog_kick_i || (tick && (soft_rst_i || wdog_fire))) begin
      wdog_cnt_d = '0;
    end else if (tick) begin
      wdog_cnt_d = wdog_cnt_q + WD_W'(1);
    end
  end

  // Watchdog state; the trip flag is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_q | wdog_fire;
    end
  end

  assign wdog_trip_o = wdog_trip_q;
`else
  logic unused_wdog;
  assign unused_wdog = wdog_kick_i ^ (WDOG_TICKS == 0);
  assign wdog_fire   = 1'b0;
  assign wdog_trip_o = 1'b0;
`endif

  // Run/halt FSM next state; only tick cycles advance it so outputs move with core clock falling edges.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (tick) begin
      if (soft_rst_i || wdog_fire) begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_d    = ST_WAIT;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
          ST_WAIT: if (deb_req_q) state_d = ST_RUN;
          ST_RUN:  if (halt_i) state_d = ST_HALT;
          ST_HALT: if (!halt_i) state_d = deb_req_q ? ST_RUN : ST_WAIT;
          default: state_d = ST_HOLD;
        endcase
      end
    end
    core_rst_n_d = (state_d != ST_HOLD);
    fetch_en_d   = (state_d == ST_RUN);
  end

  // FSM state and its registered core-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_en_q   <= fetch_en_d;
    end
  end

  // Heartbeat: high for the first half of each period, registered from the next count.
  always_comb begin
    hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + HB_W'(1);
    hb_d     = (hb_cnt_d < HB_HALF);
  end

  // Heartbeat state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b1;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign core_clk_o     = core_clk_q;
  assign tick_o         = tick;
  assign core_rst_n_o   = core_rst_n_q;
  assign fetch_enable_o = fetch_en_q;
  assign state_o        = state_q;
  assign heartbeat_o    = hb_q;

endmodule

// File: tb/tb_pulpino_boot_seq.sv
// Purpose: randomized self-checking bench for pulpino_boot_seq against a cycle-count reference model.
// Latency: model outputs compared 1 time unit after every rising clk edge.
// Backpressure: none; the bench drives levels and pulses only.
module tb_pulpino_boot_seq;

  localparam int CLK_DIV  = 2;
  localparam int RST_HOLD = 4;
  localparam int DEB      = 3;
  localparam int HB       = 10;
  localparam int WD       = 3;
`ifdef PULPINO_BOOT_SEQ_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int S_HOLD = 0, S_WAIT = 1, S_RUN = 2, S_HALT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst = 1'b0;
  logic       fetch_req_n = 1'b1;
  logic       halt = 1'b0;
  logic       kick = 1'b0;
  logic       core_clk, tick, core_rst_n, fetch_en, heartbeat, wdog_trip;
  logic [1:0] state;

  pulpino_boot_seq #(
    .CLK_DIV(CLK_DIV), .RST_HOLD_CYCLES(RST_HOLD), .DEBOUNCE_CYCLES(DEB),
    .HB_PERIOD(HB), .WDOG_TICKS(WD)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_i(soft_rst), .fetch_req_n_i(fetch_req_n),
    .halt_i(halt), .wdog_kick_i(kick), .core_clk_o(core_clk), .tick_o(tick),
    .core_rst_n_o(core_rst_n), .fetch_enable_o(fetch_en), .state_o(state),
    .heartbeat_o(heartbeat), .wdog_trip_o(wdog_trip)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since reset as a plain edge count, FSM in named states.
  int n;
  int m_state, m_holds, m_wd, m_run;
  bit m_trip, m_req, m_raw1, m_raw2, m_last_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  function automatic bit tick_at(input int k);
    return ((k % CLK_DIV) == CLK_DIV - 1) && (((k / CLK_DIV) % 2) == 1);
  endfunction

  task automatic model_reset();
    n = 0; m_state = S_HOLD; m_holds = 0; m_wd = 0; m_trip = 0;
    m_req = 0; m_raw1 = 1; m_raw2 = 1; m_last_s = 1; m_run = 0;
  endtask

  task automatic model_step();
    bit tk, fire, new_req;
    int new_wd, new_state;
    tk = tick_at(n);
    // The button is accepted once the synced level has held a new value for DEB edges.
    if (m_raw2 == m_last_s) m_run++; else m_run = 1;
    m_last_s = m_raw2;
    new_req = m_req;
    if ((!m_raw2) != m_req && m_run >= DEB) new_req = !m_raw2;
    // Watchdog: RUN ticks without a kick.
    fire = WD_EN && tk && m_state == S_RUN && !kick && !soft_rst && m_wd == WD - 1;
    if (m_state != S_RUN || kick || (tk && (soft_rst || fire))) new_wd = 0;
    else if (tk) new_wd = m_wd + 1;
    else new_wd = m_wd;
    new_state = m_state;
    if (tk) begin
      if (soft_rst || fire) begin
        new_state = S_HOLD; m_holds = 0;
      end else if (m_state == S_HOLD) begin
        m_holds++;
        if (m_holds == RST_HOLD) begin new_state = S_WAIT; m_holds = 0; end
      end else if (m_state == S_WAIT) begin
        if (m_req) new_state = S_RUN;
      end else if (m_state == S_RUN) begin
        if (halt) new_state = S_HALT;
      end else begin
        if (!halt) new_state = m_req ? S_RUN : S_WAIT;
      end
    end
    if (fire) m_trip = 1;
    m_state = new_state; m_wd = new_wd; m_req = new_req;
    m_raw2 = m_raw1; m_raw1 = fetch_req_n;
    n++;
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_state));
    chk("core_rst_n", 32'(core_rst_n), 32'(m_state != S_HOLD));
    chk("fetch_en", 32'(fetch_en), 32'(m_state == S_RUN));
    chk("core_clk", 32'(core_clk), 32'((n / CLK_DIV) % 2));
    chk("tick", 32'(tick), 32'(tick_at(n)));
    chk("heartbeat", 32'(heartbeat), 32'((n % HB) < HB / 2));
    chk("wdog_trip", 32'(wdog_trip), 32'(m_trip));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    compare_all();
  endtask

  int btn_left = 0, halt_left = 0, soft_left = 0, kick_period = 0;

  task automatic randomize_inputs(input int cyc);
    if (btn_left == 0) begin
      if ($urandom_range(0, 9) < 3) begin
        fetch_req_n = ~fetch_req_n;
        btn_left = $urandom_range(1, 3);
      end else begin
        fetch_req_n = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(10, 150);
      end
    end
    btn_left--;
    if (halt_left == 0) begin
      halt = ($urandom_range(0, 3) == 0);
      halt_left = halt ? $urandom_range(5, 60) : $urandom_range(20, 200);
    end
    halt_left--;
    if (soft_left == 0) begin
      soft_rst = ($urandom_range(0, 19) == 0);
      soft_left = soft_rst ? $urandom_range(1, 8) : $urandom_range(50, 300);
    end
    soft_left--;
    if (cyc % 500 == 0) begin
      case ($urandom_range(0, 3))
        0: kick_period = 0;
        1: kick_period = 4;
        2: kick_period = 8;
        default: kick_period = 20;
      endcase
    end
    kick = (kick_period != 0) && (cyc % kick_period == 0);
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      @(negedge clk);
      rst = 1'b1;
      cycle();
    end
    chk("rst_state", 32'(state), 32'(S_HOLD));
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_heartbeat", 32'(heartbeat), 32'd1);
    chk("rst_core_clk", 32'(core_clk), 32'd0);

    // Sequencing from reset with the button released.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (n == 3) chk("tick_before_edge4", 32'(tick), 32'd1);
      if (n == 15) chk("hold_at_edge15", 32'(core_rst_n), 32'd0);
      if (n == 16) begin
        chk("wait_at_edge16", 32'(state), 32'(S_WAIT));
        chk("rst_release_edge16", 32'(core_rst_n), 32'd1);
      end
      @(negedge clk);
    end

    // Randomized run, with one mid-run hard reset.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      randomize_inputs(cyc);
      rst = (cyc >= 1500 && cyc < 1502);
      cycle();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
